// File: rtl/imm_extend_pipe.sv
// imm_extend_pipe: registered immediate extender with a 2-entry output FIFO.
// Decodes Imm/Sa/JIdx by a 3-bit mode into an operand (ImmOut) and a
// control-flow target (TargetOut). Results are buffered in a 2-deep FIFO
// with valid/ready handshakes on both sides. Illegal requests are counted.
// Ports:
//   CLK, Reset (async active-low)
//   InValid/InReady   request handshake (InReady is purely registered)
//   ExtSel, Imm, Sa, JIdx, PCOut   request payload
//   OutValid/OutReady result handshake
//   ImmOut, TargetOut, IllegalOut  head entry
//   ErrCnt            saturating count of accepted illegal requests
module imm_extend_pipe #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16,
  parameter int SA_W   = 5,
  parameter int JIDX_W = 26,
  parameter int ERR_W  = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              InValid,
  output logic              InReady,
  input  logic [2:0]        ExtSel,
  input  logic [IMM_W-1:0]  Imm,
  input  logic [SA_W-1:0]   Sa,
  input  logic [JIDX_W-1:0] JIdx,
  input  logic [DATA_W-1:0] PCOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [DATA_W-1:0] ImmOut,
  output logic [DATA_W-1:0] TargetOut,
  output logic              IllegalOut,
  output logic [ERR_W-1:0]  ErrCnt
);

  typedef struct packed {
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] tgt;
    logic              ill;
  } ent_t;

  // Mask keeping PC bits above the jump index field. Written as a mask
  // rather than a slice so DATA_W == JIDX_W+2 remains legal.
  localparam logic [DATA_W-1:0] PC_HI_MASK = ~((DATA_W'(1) << (JIDX_W + 2)) - DATA_W'(1));

  logic [DATA_W-1:0] w_sext;
  logic [DATA_W-1:0] w_sext4;
  logic [DATA_W-1:0] w_jtgt;
  ent_t              w_new;

  always_comb begin
    w_sext  = {{(DATA_W-IMM_W){Imm[IMM_W-1]}}, Imm};
    w_sext4 = w_sext << 2;
    w_jtgt  = (PCOut & PC_HI_MASK) | (DATA_W'(JIdx) << 2);
    w_new     = '0;
    w_new.tgt = w_jtgt;
    case (ExtSel)
      3'd0: w_new.imm = DATA_W'(Sa);
      3'd1: w_new.imm = DATA_W'(Imm);
      3'd2: w_new.imm = w_sext;
      3'd3: w_new.imm = DATA_W'(Imm) << IMM_W;
      3'd4: w_new.imm = w_sext4;
      3'd5: begin
        w_new.imm = w_sext4;
        w_new.tgt = PCOut + DATA_W'(4) + w_sext4;
      end
      3'd6: w_new.imm = '0;
      default: begin
        w_new.imm = '0;
        w_new.tgt = '0;
        w_new.ill = 1'b1;
      end
    endcase
  end

  // r_head is the presented entry; r_tail holds the second entry when full.
  // The head register is only overwritten by a new head, so after the last
  // pop the outputs keep showing the popped values.
  ent_t             r_head;
  ent_t             r_tail;
  logic [1:0]       r_cnt;
  logic             r_in_rdy;
  logic [ERR_W-1:0] r_err;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;

  always_comb begin
    w_push = InValid & r_in_rdy;
    w_pop  = (r_cnt != 2'd0) & OutReady;
    case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_cnt + 2'd1;
      2'b01:   w_cnt_nxt = r_cnt - 2'd1;
      default: w_cnt_nxt = r_cnt;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_cnt    <= 2'd0;
      r_in_rdy <= 1'b0;
      r_err    <= '0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      // Registered ready: no combinational path from OutReady.
      r_in_rdy <= (w_cnt_nxt != 2'd2);
      case (r_cnt)
        2'd0: if (w_push) r_head <= w_new;
        2'd1: begin
          if (w_push && w_pop) r_head <= w_new;
          else if (w_push)     r_tail <= w_new;
        end
        default: if (w_pop) r_head <= r_tail;
      endcase
      if (w_push && (ExtSel == 3'b111) && (r_err != '1))
        r_err <= r_err + ERR_W'(1);
    end
  end

  assign InReady    = r_in_rdy;
  assign OutValid   = (r_cnt != 2'd0);
  assign ImmOut     = r_head.imm;
  assign TargetOut  = r_head.tgt;
  assign IllegalOut = r_head.ill;
  assign ErrCnt     = r_err;

endmodule

// File: tb/tb_imm_extend_pipe.sv
module tb_imm_extend_pipe;
  logic        CLK = 1'b0;
  logic        Reset;
  logic        InValid;
  logic        InReady;
  logic [2:0]  ExtSel;
  logic [15:0] Imm;
  logic [4:0]  Sa;
  logic [25:0] JIdx;
  logic [31:0] PCOut;
  logic        OutValid;
  logic        OutReady;
  logic [31:0] ImmOut;
  logic [31:0] TargetOut;
  logic        IllegalOut;
  logic [7:0]  ErrCnt;

  int nchk  = 0;
  int npass = 0;

  always #5 CLK = ~CLK;

  imm_extend_pipe dut (
    .CLK(CLK), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .ExtSel(ExtSel), .Imm(Imm), .Sa(Sa), .JIdx(JIdx), .PCOut(PCOut),
    .OutValid(OutValid), .OutReady(OutReady), .ImmOut(ImmOut),
    .TargetOut(TargetOut), .IllegalOut(IllegalOut), .ErrCnt(ErrCnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs set after this return are sampled at the next edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic req(input logic v, input logic [2:0] m, input logic [15:0] im,
                     input logic [4:0] s, input logic [25:0] j, input logic [31:0] pc);
    InValid = v; ExtSel = m; Imm = im; Sa = s; JIdx = j; PCOut = pc;
  endtask

  initial begin
    Reset = 1'b0; OutReady = 1'b0;
    req(1'b0, 3'd0, 16'h0, 5'h0, 26'h0, 32'h0);
    #12;
    chk("rst_outvalid", {31'b0, OutValid}, 32'd0);
    chk("rst_inready",  {31'b0, InReady},  32'd0);
    chk("rst_errcnt",   {24'b0, ErrCnt},   32'd0);
    chk("rst_immout",   ImmOut,            32'd0);
    chk("rst_target",   TargetOut,         32'd0);
    Reset = 1'b1;
    step();
    chk("post_rst_inready", {31'b0, InReady}, 32'd1);

    // sext, then zext with simultaneous pop
    req(1'b1, 3'd2, 16'h8001, 5'h0, 26'h0, 32'h0);
    step();
    chk("sext_valid", {31'b0, OutValid}, 32'd1);
    chk("sext_imm",   ImmOut,    32'hFFFF8001);
    chk("sext_tgt",   TargetOut, 32'h0);
    chk("sext_ill",   {31'b0, IllegalOut}, 32'd0);
    req(1'b1, 3'd1, 16'h8001, 5'h0, 26'h0, 32'h0);
    OutReady = 1'b1;
    step();
    chk("zext_valid", {31'b0, OutValid}, 32'd1);
    chk("zext_imm",   ImmOut, 32'h00008001);
    chk("pushpop_inready", {31'b0, InReady}, 32'd1);
    InValid = 1'b0;
    step();
    chk("drain_valid", {31'b0, OutValid}, 32'd0);
    chk("hold_last",   ImmOut, 32'h00008001);

    // branch target and jump target
    OutReady = 1'b0;
    req(1'b1, 3'd5, 16'hFFFE, 5'h0, 26'h0, 32'h00400010);
    step();
    chk("br_imm", ImmOut,    32'hFFFFFFF8);
    chk("br_tgt", TargetOut, 32'h0040000C);
    req(1'b1, 3'd6, 16'h1234, 5'h0, 26'h0000004, 32'hA0000000);
    OutReady = 1'b1;
    step();
    chk("j_tgt", TargetOut, 32'hA0000010);
    chk("j_imm", ImmOut,    32'h0);
    req(1'b1, 3'd0, 16'hFFFF, 5'h1F, 26'h3FFFFFF, 32'hF0000000);
    step();
    chk("sa_imm", ImmOut,    32'h0000001F);
    chk("sa_tgt", TargetOut, 32'hFFFFFFFC);
    req(1'b1, 3'd4, 16'h8000, 5'h0, 26'h0, 32'h0);
    step();
    chk("sh2_imm", ImmOut, 32'hFFFE0000);
    InValid = 1'b0;
    step();
    chk("drain2_valid", {31'b0, OutValid}, 32'd0);

    // backpressure: 3 back-to-back with OutReady=0
    OutReady = 1'b0;
    req(1'b1, 3'd0, 16'h0, 5'd1, 26'h0, 32'h0);
    step();
    chk("bp1_inready", {31'b0, InReady}, 32'd1);
    req(1'b1, 3'd0, 16'h0, 5'd2, 26'h0, 32'h0);
    step();
    chk("bp2_inready", {31'b0, InReady}, 32'd0);
    chk("bp2_head",    ImmOut, 32'd1);
    req(1'b1, 3'd0, 16'h0, 5'd3, 26'h0, 32'h0);
    step();
    chk("bp3_inready", {31'b0, InReady}, 32'd0);
    chk("bp3_head",    ImmOut, 32'd1);
    step();
    chk("bp4_head",    ImmOut, 32'd1);
    OutReady = 1'b1;
    step();
    chk("bp_out2",        ImmOut, 32'd2);
    chk("bp_out2_inrdy",  {31'b0, InReady}, 32'd1);
    step();
    chk("bp_out3",        ImmOut, 32'd3);
    chk("bp_out3_valid",  {31'b0, OutValid}, 32'd1);
    InValid = 1'b0;
    step();
    chk("bp_empty", {31'b0, OutValid}, 32'd0);

    // illegal flood with continuous pop
    req(1'b1, 3'd7, 16'hFFFF, 5'h1F, 26'h1, 32'hFFFFFFFF);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i == 1 || i == 150 || i == 300) begin
        chk("ill_flag", {31'b0, IllegalOut}, 32'd1);
        chk("ill_imm",  ImmOut,    32'd0);
        chk("ill_tgt",  TargetOut, 32'd0);
      end
      if (i == 10)  chk("err_10",  {24'b0, ErrCnt}, 32'd10);
      if (i == 255) chk("err_255", {24'b0, ErrCnt}, 32'd255);
    end
    chk("err_sat", {24'b0, ErrCnt}, 32'hFF);
    req(1'b1, 3'd3, 16'h1234, 5'h0, 26'h0, 32'h0);
    step();
    chk("lui_imm",   ImmOut, 32'h12340000);
    chk("lui_ill",   {31'b0, IllegalOut}, 32'd0);
    chk("err_hold",  {24'b0, ErrCnt}, 32'hFF);
    InValid = 1'b0;
    step();

    // reset with two entries buffered
    OutReady = 1'b0;
    req(1'b1, 3'd7, 16'h0, 5'd0, 26'h0, 32'h0);
    step();
    req(1'b1, 3'd0, 16'h0, 5'd9, 26'h0, 32'h0);
    step();
    chk("full_inready", {31'b0, InReady}, 32'd0);
    InValid = 1'b0;
    #2 Reset = 1'b0;
    #1;
    chk("mid_rst_valid",  {31'b0, OutValid}, 32'd0);
    chk("mid_rst_err",    {24'b0, ErrCnt},   32'd0);
    chk("mid_rst_inrdy",  {31'b0, InReady},  32'd0);
    chk("mid_rst_imm",    ImmOut, 32'd0);
    #1 Reset = 1'b1;
    step();
    chk("rel_inready", {31'b0, InReady}, 32'd1);
    chk("rel_valid",   {31'b0, OutValid}, 32'd0);
    req(1'b1, 3'd1, 16'h0055, 5'd0, 26'h0, 32'h0);
    step();
    chk("post_valid", {31'b0, OutValid}, 32'd1);
    chk("post_imm",   ImmOut, 32'h55);
    InValid = 1'b0;
    OutReady = 1'b1;
    step();
    chk("post_alone", {31'b0, OutValid}, 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
